// File: rtl/wordle_scorer.sv
// Multi-cycle Wordle guess scorer: a green pass then a yellow pass, one letter per cycle, with a Start/Ack handshake.
// Optional guess validation is enabled by defining WORDLE_SCORER_VALIDATE_EN.
module wordle_scorer (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic [39:0] guessWord,
  input  logic [39:0] randomWord,
  output logic [9:0]  colors,
  output logic        all_green,
  output logic        invalid,
  output logic        q_I,
  output logic        q_Green,
  output logic        q_Yellow,
  output logic        q_Done
);

  typedef enum logic [3:0] {
    QI      = 4'b0001,
    QGREEN  = 4'b0010,
    QYELLOW = 4'b0100,
    QDONE   = 4'b1000
  } state_t;

  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b01;

  state_t      state, state_n;
  logic [2:0]  i;
  logic [4:0]  consumed;
  logic [39:0] gw, aw;
  logic [7:0]  g [0:4];
  logic [7:0]  a [0:4];
  logic [1:0]  col [0:4];
  logic        inv_q;
  logic        hit;
  logic [2:0]  hit_k;

  for (genvar p = 0; p < 5; p++) begin : g_pos
    assign g[p] = gw[39-8*p -: 8];
    assign a[p] = aw[39-8*p -: 8];
    assign colors[9-2*p -: 2] = col[p];
  end

`ifdef WORDLE_SCORER_VALIDATE_EN
  function automatic logic bad_guess(input logic [39:0] w);
    logic bad;
    bad = 1'b0;
    for (int p = 0; p < 5; p++)
      if (w[39-8*p -: 8] < 8'h41 || w[39-8*p -: 8] > 8'h5A) bad = 1'b1;
    return bad;
  endfunction

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)                    inv_q <= 1'b0;
    else if (state == QI && Start) inv_q <= bad_guess(guessWord);
  end
`else
  assign inv_q = 1'b0;
`endif

  assign invalid  = inv_q;
  assign q_I      = state[0];
  assign q_Green  = state[1];
  assign q_Yellow = state[2];
  assign q_Done   = state[3];

  // Lowest unconsumed answer position holding the current guess letter.
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (!hit && !consumed[k] && a[k] == g[i]) begin
        hit   = 1'b1;
        hit_k = k[2:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= QI;
    else       state <= state_n;
  end

  // An invalid guess spends its single QGREEN cycle and then jumps to QDONE.
  always_comb begin
    state_n = QI;
    case (state)
      QI:      state_n = Start ? QGREEN : QI;
      QGREEN:  state_n = (inv_q || i == 3'd4) ? ((inv_q) ? QDONE : QYELLOW) : QGREEN;
      QYELLOW: state_n = (i == 3'd4) ? QDONE : QYELLOW;
      QDONE:   state_n = Ack ? QI : QDONE;
      default: state_n = QI;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      i         <= 3'd0;
      consumed  <= 5'd0;
      gw        <= 40'd0;
      aw        <= 40'd0;
      all_green <= 1'b0;
      for (int p = 0; p < 5; p++) col[p] <= 2'b00;
    end else begin
      case (state)
        QI: if (Start) begin
          gw        <= guessWord;
          aw        <= randomWord;
          i         <= 3'd0;
          consumed  <= 5'd0;
          all_green <= 1'b0;
          for (int p = 0; p < 5; p++) col[p] <= 2'b00;
        end
        QGREEN: begin
          if (!inv_q && g[i] == a[i]) begin
            col[i]      <= GREEN;
            consumed[i] <= 1'b1;
          end
          i <= (i == 3'd4 || inv_q) ? 3'd0 : i + 3'd1;
        end
        QYELLOW: begin
          if (col[i] != GREEN && hit) begin
            col[i]          <= YELLOW;
            consumed[hit_k] <= 1'b1;
          end
          if (i == 3'd4) begin
            i         <= 3'd0;
            all_green <= (gw == aw);
          end else begin
            i <= i + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
